// File: rtl/instmem_loader.sv
// Instruction memory with a valid/ready burst-load port (auto-incrementing address) and a registered fetch port.
// Optional feature macro INSTMEM_PARITY_EN: stores an even-parity bit per word and adds output parity_err_IM.
module instmem_loader #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = (1 << ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start_IM,
  input  logic [ADDR_W-1:0] load_base_IM,
  input  logic [ADDR_W:0]   load_len_IM,
  input  logic              load_valid_IM,
  input  logic [DATA_W-1:0] load_data_IM,
  output logic              load_ready_IM,
  output logic              load_busy_IM,
  output logic              load_done_IM,
  output logic [ADDR_W:0]   load_count_IM,
  input  logic              fetch_en_IM,
  input  logic [ADDR_W-1:0] fetch_addr_IM,
  output logic [DATA_W-1:0] outIM,
`ifdef INSTMEM_PARITY_EN
  output logic              parity_err_IM,
`endif
  output logic              out_valid_IM
);

  localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef INSTMEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  state_t            stateNext;
  logic              readyNext;
  logic              busyNext;
  logic              doneNext;
  logic              startAcc;
  logic              fetchAcc;
  logic              beat;
  logic [ADDR_W-1:0] waddr;
  logic [CNT_W-1:0]  lenQ;
  logic [WORD_W-1:0] wordIn;
  logic [WORD_W-1:0] rdWord;
  logic              addrInRange;

  logic [WORD_W-1:0] mem [DEPTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state and registered-output decode
  always_comb begin
    stateNext = state;
    readyNext = 1'b0;
    busyNext  = 1'b0;
    doneNext  = 1'b0;
    startAcc  = (state == IDLE) && load_start_IM;
    fetchAcc  = (state == IDLE) && fetch_en_IM && !load_start_IM;
    beat      = (state == LOAD) && load_valid_IM && load_ready_IM;
    case (state)
      IDLE: begin
        if (load_start_IM) stateNext = (load_len_IM == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (beat && (CNT_W'(load_count_IM + CNT_W'(1)) == lenQ)) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    readyNext = (stateNext == LOAD);
    busyNext  = (stateNext != IDLE);
    doneNext  = (stateNext == DONE);
  end

  // Load-side registers: status flags, write pointer, session length and beat count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_ready_IM <= 1'b0;
      load_busy_IM  <= 1'b0;
      load_done_IM  <= 1'b0;
      load_count_IM <= '0;
      waddr         <= '0;
      lenQ          <= '0;
    end else begin
      load_ready_IM <= readyNext;
      load_busy_IM  <= busyNext;
      load_done_IM  <= doneNext;
      if (startAcc) begin
        waddr         <= load_base_IM;
        lenQ          <= load_len_IM;
        load_count_IM <= '0;
      end else if (beat) begin
        waddr         <= (waddr == ADDR_W'(DEPTH - 1)) ? '0 : ADDR_W'(waddr + ADDR_W'(1));
        load_count_IM <= CNT_W'(load_count_IM + CNT_W'(1));
      end
    end
  end

`ifdef INSTMEM_PARITY_EN
  assign wordIn = {^load_data_IM, load_data_IM};
`else
  assign wordIn = load_data_IM;
`endif

  // Storage array is intentionally not reset
  always_ff @(posedge clk) begin
    if (beat) mem[waddr] <= wordIn;
  end

  assign addrInRange = (32'(fetch_addr_IM) < DEPTH);
  assign rdWord      = addrInRange ? mem[fetch_addr_IM] : '0;

  // Registered fetch port; data holds when no fetch is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outIM         <= '0;
      out_valid_IM  <= 1'b0;
`ifdef INSTMEM_PARITY_EN
      parity_err_IM <= 1'b0;
`endif
    end else begin
      out_valid_IM <= fetchAcc;
      if (fetchAcc) begin
        outIM         <= rdWord[DATA_W-1:0];
`ifdef INSTMEM_PARITY_EN
        parity_err_IM <= ^rdWord;
`endif
      end
    end
  end

endmodule

// File: tb/tb_instmem_loader.sv
// Self-checking bench for instmem_loader: directed corner sequences, a fetch vector table,
// and randomized load sessions checked against an address-indexed memory model.
module tb_instmem_loader;
  localparam int unsigned DATA_W = 19;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = (1 << ADDR_W);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start_IM = 1'b0;
  logic [ADDR_W-1:0] load_base_IM = '0;
  logic [ADDR_W:0]   load_len_IM = '0;
  logic              load_valid_IM = 1'b0;
  logic [DATA_W-1:0] load_data_IM = '0;
  logic              load_ready_IM;
  logic              load_busy_IM;
  logic              load_done_IM;
  logic [ADDR_W:0]   load_count_IM;
  logic              fetch_en_IM = 1'b0;
  logic [ADDR_W-1:0] fetch_addr_IM = '0;
  logic [DATA_W-1:0] outIM;
  logic              out_valid_IM;
`ifdef INSTMEM_PARITY_EN
  logic              parity_err_IM;
`endif

  int checks = 0;
  int errors = 0;
  int sessBase = 0;
  logic [DATA_W-1:0] refMem [int];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fetchVec_t;
  fetchVec_t vecs[$];

  instmem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_start_IM(load_start_IM),
    .load_base_IM(load_base_IM),
    .load_len_IM(load_len_IM),
    .load_valid_IM(load_valid_IM),
    .load_data_IM(load_data_IM),
    .load_ready_IM(load_ready_IM),
    .load_busy_IM(load_busy_IM),
    .load_done_IM(load_done_IM),
    .load_count_IM(load_count_IM),
    .fetch_en_IM(fetch_en_IM),
    .fetch_addr_IM(fetch_addr_IM),
    .outIM(outIM),
`ifdef INSTMEM_PARITY_EN
    .parity_err_IM(parity_err_IM),
`endif
    .out_valid_IM(out_valid_IM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_ready"}, 32'(load_ready_IM), 0);
    chk({tag, "_busy"},  32'(load_busy_IM), 0);
    chk({tag, "_done"},  32'(load_done_IM), 0);
    chk({tag, "_count"}, 32'(load_count_IM), 0);
    chk({tag, "_out"},   32'(outIM), 0);
    chk({tag, "_valid"}, 32'(out_valid_IM), 0);
`ifdef INSTMEM_PARITY_EN
    chk({tag, "_perr"},  32'(parity_err_IM), 0);
`endif
  endtask

  task automatic startLoad(input int base, input int len);
    sessBase      = base;
    load_start_IM = 1'b1;
    load_base_IM  = ADDR_W'(base);
    load_len_IM   = (ADDR_W+1)'(len);
    tick();
    load_start_IM = 1'b0;
    chk("start_count", 32'(load_count_IM), 0);
    chk("start_busy",  32'(load_busy_IM), 1);
    chk("start_ready", 32'(load_ready_IM), (len != 0) ? 1 : 0);
    chk("start_done",  32'(load_done_IM), (len == 0) ? 1 : 0);
  endtask

  // Streams words with random valid gaps; every valid cycle in LOAD is a beat.
  task automatic feedWords(input logic [DATA_W-1:0] words[$], input int gapPct);
    int idx = 0;
    int cyc = 0;
    while (idx < words.size() && cyc < 400) begin
      load_valid_IM = ($urandom_range(99) >= 32'(gapPct));
      load_data_IM  = load_valid_IM ? words[idx] : DATA_W'($urandom);
      chk("ready_in_load", 32'(load_ready_IM), 1);
      if (load_valid_IM) begin
        refMem[(sessBase + idx) % int'(DEPTH)] = words[idx];
        idx++;
      end
      tick();
      cyc++;
      if (idx < words.size()) chk("count_mid", 32'(load_count_IM), 32'(idx));
    end
    load_valid_IM = 1'b0;
    if (idx < words.size()) chk("feed_timeout", 32'(idx), 32'(words.size()));
    chk("done_pulse",  32'(load_done_IM), 1);
    chk("done_busy",   32'(load_busy_IM), 1);
    chk("done_ready",  32'(load_ready_IM), 0);
    chk("done_count",  32'(load_count_IM), 32'(words.size()));
    tick();
    chk("done_clear",  32'(load_done_IM), 0);
    chk("idle_busy",   32'(load_busy_IM), 0);
    chk("count_hold",  32'(load_count_IM), 32'(words.size()));
  endtask

  task automatic doFetch(input int addr, input logic [DATA_W-1:0] exp, input bit checkData);
    fetch_en_IM   = 1'b1;
    fetch_addr_IM = ADDR_W'(addr);
    tick();
    fetch_en_IM   = 1'b0;
    chk("fetch_valid", 32'(out_valid_IM), 1);
    if (checkData) chk($sformatf("fetch_data@%0d", addr), 32'(outIM), 32'(exp));
`ifdef INSTMEM_PARITY_EN
    if (checkData) chk("fetch_perr", 32'(parity_err_IM), 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] w[$];
    logic [DATA_W-1:0] pat[5];
    int keys[$];
    int a;
    int n;

    vecs = {};
    vecs.push_back('{addr: ADDR_W'(1),         data: 19'h00381});
    vecs.push_back('{addr: ADDR_W'(10),        data: 19'h12345});
    vecs.push_back('{addr: ADDR_W'(11),        data: 19'h6789A});
    vecs.push_back('{addr: ADDR_W'(12),        data: 19'h0BCDE});
    vecs.push_back('{addr: ADDR_W'(DEPTH - 1), data: 19'h7FFFF});
    vecs.push_back('{addr: ADDR_W'(0),         data: 19'h00001});
    vecs.push_back('{addr: ADDR_W'(100),       data: 19'h11111});
    vecs.push_back('{addr: ADDR_W'(101),       data: 19'h22222});
    vecs.push_back('{addr: ADDR_W'(300),       data: 19'h5A5A5});

    // Reset: all outputs zero while held
    repeat (3) @(posedge clk);
    #1;
    chkAllZero("reset");
    rst_n = 1'b1;
    tick();
    doFetch(0, '0, 1'b0);
    tick();
    chk("valid_one_cycle", 32'(out_valid_IM), 0);

    // Basic two-word load
    startLoad(0, 2);
    w = {19'h00234, 19'h00381};
    feedWords(w, 0);
    doFetch(0, 19'h00234, 1'b1);
    doFetch(1, 19'h00381, 1'b1);

    // Toggled valid, fetch held high through the session; start also beats the fetch
    pat[0] = 19'h12345; pat[1] = 19'h00F0F; pat[2] = 19'h6789A;
    pat[3] = 19'h00F0F; pat[4] = 19'h0BCDE;
    fetch_en_IM   = 1'b1;
    fetch_addr_IM = ADDR_W'(1);
    startLoad(10, 3);
    chk("start_beats_fetch", 32'(out_valid_IM), 0);
    for (int k = 0; k < 5; k++) begin
      load_valid_IM = (k % 2 == 0);
      load_data_IM  = pat[k];
      tick();
      chk("fetch_blocked", 32'(out_valid_IM), 0);
      chk("toggle_count", 32'(load_count_IM), 32'(k / 2 + 1));
      chk("toggle_done", 32'(load_done_IM), (k == 4) ? 1 : 0);
    end
    fetch_en_IM   = 1'b0;
    load_valid_IM = 1'b0;
    tick();
    chk("toggle_fetch_in_done", 32'(out_valid_IM), 0);
    chk("toggle_done_clear", 32'(load_done_IM), 0);
    refMem[10] = pat[0]; refMem[11] = pat[2]; refMem[12] = pat[4];

    // Address wrap at the top of memory
    startLoad(int'(DEPTH - 1), 2);
    w = {19'h7FFFF, 19'h00001};
    feedWords(w, 30);

    // Zero-length session
    startLoad(0, 0);
    tick();
    chk("len0_done_clear", 32'(load_done_IM), 0);
    chk("len0_busy_clear", 32'(load_busy_IM), 0);
    chk("len0_count", 32'(load_count_IM), 0);

    // Second start during LOAD is ignored
    startLoad(100, 2);
    load_start_IM = 1'b1;
    load_base_IM  = ADDR_W'(200);
    load_len_IM   = (ADDR_W+1)'(5);
    tick();
    load_start_IM = 1'b0;
    chk("restart_ignored_count", 32'(load_count_IM), 0);
    chk("restart_ignored_busy", 32'(load_busy_IM), 1);
    w = {19'h11111, 19'h22222};
    feedWords(w, 0);

    // Reset in the middle of a four-word load
    startLoad(300, 4);
    load_valid_IM = 1'b1;
    load_data_IM  = 19'h5A5A5;
    tick();
    load_valid_IM = 1'b0;
    refMem[300] = 19'h5A5A5;
    chk("midload_count", 32'(load_count_IM), 1);
    #2 rst_n = 1'b0;
    #1;
    chkAllZero("midload_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chkAllZero("after_reset");

    // Table of expected memory contents
    for (int i = 0; i < vecs.size(); i++) begin
      doFetch(int'(vecs[i].addr), vecs[i].data, 1'b1);
    end

    // Randomized sessions against the memory model
    for (int s = 0; s < 15; s++) begin
      a = int'($urandom_range(DEPTH - 1));
      n = int'($urandom_range(8, 1));
      w = {};
      for (int j = 0; j < n; j++) w.push_back(DATA_W'($urandom));
      startLoad(a, n);
      feedWords(w, 40);
    end
    keys = {};
    foreach (refMem[k]) keys.push_back(k);
    for (int f = 0; f < 40; f++) begin
      a = keys[$urandom_range(keys.size() - 1)];
      doFetch(a, refMem[a], 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
